// File: rtl/tone_oscillator_pkg.sv
// Shared constants and state type for the tone generation chain.
// The lookup stage and the later mixer stages reuse these definitions.
package tone_oscillator_pkg;

    localparam int unsigned DIV_W    = 19;
    localparam int unsigned OFF_CODE = 370000;

    typedef enum logic {
        MUTE,
        RUN
    } osc_state_t;

endpackage

// File: rtl/tone_oscillator_edge_counter.sv
// Free-running counter that wraps to zero after reaching load_val-1.
// Raises done during the terminal count.
module edge_counter #(
    parameter int unsigned DIV_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] load_val,
    output logic             done
);

    logic [DIV_W-1:0] cnt;

    assign done = (cnt == load_val - DIV_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/tone_oscillator.sv
// Square-wave oscillator with a half-period divider and a tick on every edge.
// A new divider is adopted only at a half-period boundary, so the output never glitches.
module tone_oscillator #(
    parameter int unsigned DIV_W    = tone_oscillator_pkg::DIV_W,
    parameter int unsigned OFF_CODE = tone_oscillator_pkg::OFF_CODE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] divider,
    output logic             wave_out,
    output logic             half_tick,
    output logic             active
);

    import tone_oscillator_pkg::*;

    osc_state_t       state;
    logic             en_q;
    logic [DIV_W-1:0] din_q;
    logic [DIV_W-1:0] div_q;
    logic             mute_req;
    logic             cnt_clr;
    logic             cnt_done;

    assign mute_req = !en_q || (din_q == DIV_W'(OFF_CODE)) || (din_q == '0);
    // Hold the counter at zero while muted so RUN always starts from a fresh half-period.
    assign cnt_clr  = (state == MUTE) || mute_req;

    edge_counter #(
        .DIV_W (DIV_W)
    ) u_edge_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load_val (div_q),
        .done     (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b0;
            din_q     <= '0;
            div_q     <= '0;
            state     <= MUTE;
            wave_out  <= 1'b0;
            half_tick <= 1'b0;
            active    <= 1'b0;
        end else begin
            en_q  <= en;
            din_q <= divider;
            case (state)
                MUTE: begin
                    wave_out  <= 1'b0;
                    half_tick <= 1'b0;
                    active    <= 1'b0;
                    if (!mute_req) begin
                        div_q  <= din_q;
                        state  <= RUN;
                        active <= 1'b1;
                    end
                end
                RUN: begin
                    if (mute_req) begin
                        // Mute wins over a coincident terminal count.
                        state     <= MUTE;
                        wave_out  <= 1'b0;
                        half_tick <= 1'b0;
                        active    <= 1'b0;
                    end else if (cnt_done) begin
                        wave_out  <= ~wave_out;
                        half_tick <= 1'b1;
                        div_q     <= din_q;
                    end else begin
                        half_tick <= 1'b0;
                    end
                end
                default: begin
                    state <= MUTE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_oscillator.sv
// Directed bench for tone_oscillator: cycle model feeds a scoreboard, plus
// explicit latency/period checks from the test plan.
module tb_tone_oscillator;

    localparam int OFF = 370000;

    logic        clk;
    logic        rst;
    logic        en;
    logic [18:0] divider;
    logic        wave_out;
    logic        half_tick;
    logic        active;

    tone_oscillator dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .divider   (divider),
        .wave_out  (wave_out),
        .half_tick (half_tick),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic w;
        logic t;
        logic a;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state
    bit m_run;
    bit m_en_q;
    int m_din_q;
    int m_div;
    int m_cnt;
    bit m_w;
    bit m_t;
    bit m_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run   = 0;
        m_en_q  = 0;
        m_din_q = 0;
        m_div   = 0;
        m_cnt   = 0;
        m_w     = 0;
        m_t     = 0;
        m_a     = 0;
    endtask

    task automatic model_step();
        bit mute;
        mute = !m_en_q || (m_din_q == OFF) || (m_din_q == 0);
        if (!m_run) begin
            m_w = 0;
            m_t = 0;
            m_a = 0;
            m_cnt = 0;
            if (!mute) begin
                m_run = 1;
                m_div = m_din_q;
                m_a   = 1;
            end
        end else if (mute) begin
            m_run = 0;
            m_w   = 0;
            m_t   = 0;
            m_a   = 0;
            m_cnt = 0;
        end else if (m_cnt == m_div - 1) begin
            m_cnt = 0;
            m_w   = !m_w;
            m_t   = 1;
            m_div = m_din_q;
        end else begin
            m_cnt++;
            m_t = 0;
        end
        m_en_q  = en;
        m_din_q = int'(divider);
    endtask

    // One clock: predict, push, clock, pop and compare.
    task automatic cycle();
        exp_t e;
        model_step();
        e.w = m_w;
        e.t = m_t;
        e.a = m_a;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("cyc", {29'd0, wave_out, half_tick, active}, {29'd0, e.w, e.t, e.a});
    endtask

    task automatic wait_tick(input string tag, input int max, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!half_tick && n < max);
        check(tag, half_tick, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  bad;
        int  sum;
        bit  seen;
        logic prev;

        rst = 1'b1;
        en = 1'b0;
        divider = '0;
        model_reset();
        #2;
        check("reset_out", {29'd0, wave_out, half_tick, active}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Off code keeps the oscillator silent.
        en = 1'b1;
        divider = 19'(OFF);
        seen = 0;
        repeat (50) begin
            cycle();
            if (half_tick) seen = 1;
        end
        check("mute_tick", seen, 0);
        check("mute_active", active, 0);
        check("mute_wave", wave_out, 0);

        // Steady tone, divider 4.
        divider = 19'd4;
        cycle();
        check("st_act0", active, 0);
        cycle();
        check("st_act", active, 1);
        wait_tick("st_first", 10, n);
        check("st_rise_lat", n, 4);
        check("st_rise", wave_out, 1);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            wait_tick("st_tick", 10, n);
            if (n != 4) bad++;
        end
        check("st_period", bad, 0);

        // Shadow update: 10 -> 3 in the middle of a half-period.
        divider = 19'd10;
        wait_tick("sh_a", 12, n);
        wait_tick("sh_b", 12, n);
        check("sh_len10", n, 10);
        repeat (4) cycle();
        divider = 19'd3;
        wait_tick("sh_c", 12, n);
        check("sh_hold", n + 4, 10);
        wait_tick("sh_d", 12, n);
        check("sh_len3a", n, 3);
        wait_tick("sh_e", 12, n);
        check("sh_len3b", n, 3);

        // Minimum divider.
        en = 1'b0;
        repeat (3) cycle();
        check("min_off", active, 0);
        en = 1'b1;
        divider = 19'd1;
        repeat (2) cycle();
        check("min_act", active, 1);
        prev = wave_out;
        bad = 0;
        repeat (20) begin
            cycle();
            if (!half_tick || wave_out == prev) bad++;
            prev = wave_out;
        end
        check("min_toggle", bad, 0);
        divider = 19'd0;
        repeat (2) cycle();
        check("min_mute", {30'd0, active, wave_out}, 0);

        // Mute on a terminal-count cycle, then restart.
        divider = 19'd6;
        wait_tick("mm_first", 12, n);
        check("mm_lat", n, 8);
        repeat (4) cycle();
        en = 1'b0;
        cycle();
        check("mm_pre", active, 1);
        cycle();
        check("mm_off", {29'd0, wave_out, active, half_tick}, 0);
        en = 1'b1;
        wait_tick("mm_re", 12, n);
        check("mm_relat", n, 8);
        check("mm_rewave", wave_out, 1);

        // Asynchronous reset between edges while wave_out is high.
        #2;
        rst = 1'b1;
        #1;
        check("ar_now", {29'd0, wave_out, half_tick, active}, 0);
        model_reset();
        @(posedge clk);
        #1;
        check("ar_hold", {29'd0, wave_out, half_tick, active}, 0);
        en = 1'b1;
        divider = 19'd5;
        rst = 1'b0;
        wait_tick("ar_first", 12, n);
        check("ar_lat", n, 7);
        check("ar_wave", wave_out, 1);
        wait_tick("ar_h1", 12, n);
        sum = n;
        wait_tick("ar_h2", 12, n);
        sum += n;
        check("ar_period", sum, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tone_oscillator.md
Name: tone_oscillator

Overview:
- Sits directly downstream of the note/octave-to-divider lookup stage.
- Consumes the 19-bit half-period divider and produces a 50%-duty square wave for the audio output path.
- Adds a per-half-period tick for later envelope and mixer stages.
- Keeps divider changes glitch-free: a new divider takes effect only at a half-period boundary.

Parameters:
- DIV_W, 19, width of the divider input and the internal counter.
- OFF_CODE, 370000, divider value that means the note is off (mute).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  oscillator enable; low forces the mute state
- divider  input  DIV_W  half-period length in clk cycles; driven by the lookup stage
- wave_out  output  1  square wave
- half_tick  output  1  one-cycle pulse on each wave_out toggle
- active  output  1  high while the oscillator is running, i.e. not muted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: wave_out=0, half_tick=0, active=0, cnt=0, div_q=0, state=MUTE.
- Registered inputs:
  - en and divider are sampled into registers en_q and din_q, giving one cycle of input latency.
  - All decisions below use en_q and din_q.
  - mute_req = !en_q || din_q==OFF_CODE || din_q==0.
- State MUTE:
  - Outputs: cnt=0, wave_out=0, active=0, half_tick=0.
  - If !mute_req: load div_q<=din_q, cnt<=0, go to RUN.
  - active rises in the cycle that RUN is entered.
- State RUN, counting:
  - cnt increments by 1 per cycle.
  - When cnt==div_q-1 (terminal): cnt<=0, wave_out toggles, half_tick=1 for that cycle, div_q<=din_q (shadow update).
- Period and latency:
  - Full period = 2*div_q cycles.
  - First wave_out rise occurs div_q cycles after RUN entry.
  - half_tick is registered and coincident with the wave_out edge.
- Divider change in RUN: din_q changes mid-half-period have no effect until the next terminal. No truncation or extension of the current half-period.
- Mute in RUN:
  - mute_req high in any RUN cycle returns to MUTE next cycle: wave_out<=0, cnt<=0, active<=0, no half_tick.
  - Mute overrides a simultaneous terminal event.
- div_q==1: wave_out toggles every cycle and half_tick is held high continuously.
- Counter wrap: cnt never exceeds div_q-1. DIV_W bits always suffice because div_q < 2^DIV_W.
- Reset mid-operation: immediate return to the reset values; no partial-period output after release.
- Combinational paths: none from inputs to outputs.

Decomposition:
- Shared package (e.g. sass_pkg):
  - OFF_CODE constant and DIV_W.
  - Enum osc_state_t {MUTE, RUN}.
  - Both are reused by the lookup stage's default case and by later mixer stages.
- Sub-module edge_counter (natural split):
  - Terminal-count counter with load and clear.
  - Ports: clk, rst, clr, load_val, done.
- tone_oscillator keeps the input registers, FSM, shadow divider and output toggle.

Test Plan:
- Reset/mute: rst pulse, then en=1, divider=370000 for 50 cycles -> wave_out=0, active=0, half_tick never asserted.
- Steady tone: en=1, divider=4 -> active high 2 cycles after the stimulus edge; wave_out first rises 4 cycles after RUN entry; period exactly 8 cycles; half_tick every 4 cycles; 100 periods checked.
- Shadow update: divider=10, then switch to divider=3 at cycle 5 of a half-period -> current half-period still 10 cycles, following half-periods 3 cycles, no runt pulse.
- Minimum divider: divider=1 -> wave_out toggles every cycle, half_tick constantly high; then divider=0 -> MUTE within 2 cycles, wave_out=0.
- Mute mid-run: divider=6 running, en dropped on a terminal-count cycle -> next cycle wave_out=0, active=0, no half_tick; en re-raised -> fresh RUN with cnt from 0 and first rise after 6 cycles.
- Async reset mid-run: assert rst between clock edges while wave_out=1 -> wave_out, active and half_tick go 0 without a clock edge; after release with en=1, divider=5 -> normal restart, period 10 cycles.
